// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold/load/clear plus multi-step shift, rotate and
// arithmetic-shift commands with serial in/out and a start/busy/done handshake.
module univ_shift_reg #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CW-1:0]    count,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      ModeNop   = 3'b000,
      ModeShl   = 3'b001,
      ModeShr   = 3'b010,
      ModeLoad  = 3'b011,
      ModeRol   = 3'b100,
      ModeRor   = 3'b101,
      ModeAsr   = 3'b110,
      ModeClear = 3'b111
   } mode_e;

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_val;
   logic             step_out;
   logic [CW-1:0]    eff_count;

   // One single-bit step of the latched multi-step mode.
   always_comb begin
      step_val = q_q;
      step_out = sout_q;
      case (mode_q)
         ModeShl: begin
            step_val = {q_q[WIDTH-2:0], sin};
            step_out = q_q[WIDTH-1];
         end
         ModeShr: begin
            step_val = {sin, q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         ModeRol: begin
            step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            step_out = q_q[WIDTH-1];
         end
         ModeRor: begin
            step_val = {q_q[0], q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         ModeAsr: begin
            step_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         default: ;
      endcase
   end

   assign eff_count = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      q_d     = q_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               case (mode)
                  ModeNop: done_d = 1'b1;
                  ModeLoad: begin
                     q_d    = d;
                     done_d = 1'b1;
                  end
                  ModeClear: begin
                     q_d    = '0;
                     done_d = 1'b1;
                  end
                  default: begin
                     // A zero-length shift completes immediately, like a NOP.
                     if (count == '0) begin
                        done_d = 1'b1;
                     end else begin
                        mode_d  = mode;
                        rem_d   = eff_count;
                        state_d = StShift;
                     end
                  end
               endcase
            end
         end
         StShift: begin
            q_d    = step_val;
            sout_d = step_out;
            rem_d  = rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         mode_q  <= 3'b000;
         rem_q   <= '0;
         q_q     <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign busy = (state_q == StShift);
   assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios then random commands, checked against an
// arithmetic reference model of the register.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic [CW-1:0] count = '0;
   logic [W-1:0]  d = '0;
   logic          sin = 1'b0;
   logic [W-1:0]  q;
   logic          sout;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int mq = 0;
   int msout = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .count (count),
      .d     (d),
      .sin   (sin),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ebusy, input int edone);
      chk({tag, ".q"}, 32'(q), mq);
      chk({tag, ".sout"}, 32'(sout), msout);
      chk({tag, ".busy"}, 32'(busy), ebusy);
      chk({tag, ".done"}, 32'(done), edone);
   endtask

   // Reference step computed with plain integer arithmetic.
   function automatic int step_fn(input int m, input int v, input int s, output int so);
      int top;
      int full;
      top  = 1 << (W - 1);
      full = 1 << W;
      so   = 0;
      case (m)
         1: begin so = v / top; return (v * 2 + s) % full; end
         2: begin so = v % 2;   return v / 2 + s * top; end
         4: begin so = v / top; return (v * 2) % full + v / top; end
         5: begin so = v % 2;   return v / 2 + (v % 2) * top; end
         6: begin so = v % 2;   return v / 2 + ((v >= top) ? top : 0); end
         default: return v;
      endcase
   endfunction

   task automatic do_cmd(input int m, input int c, input int dv, input int fixed_sin,
                         input bit poke);
      int n;
      int sb;
      int so;
      start = 1'b1;
      mode  = m[2:0];
      count = c[CW-1:0];
      d     = dv[W-1:0];
      tick();
      start = 1'b0;
      if (m == 3) mq = dv;
      else if (m == 7) mq = 0;
      if (m == 0 || m == 3 || m == 7 || c == 0) begin
         chk_all("single", 0, 1);
         return;
      end
      n = (c > W) ? W : c;
      chk_all("accept", 1, 0);
      for (int k = 1; k <= n; k++) begin
         sb  = (fixed_sin >= 0) ? fixed_sin : int'($urandom_range(1, 0));
         sin = sb[0];
         if (poke) begin
            start = 1'b1;
            mode  = 3'b011;
            d     = '1;
            count = '0;
         end
         tick();
         start = 1'b0;
         mq    = step_fn(m, mq, sb, so);
         msout = so;
         chk_all("step", (k < n) ? 1 : 0, (k == n) ? 1 : 0);
      end
   endtask

   initial begin
      // Asynchronous reset, checked without waiting for a clock edge.
      #1 reset = 1'b0;
      #1;
      chk_all("reset", 0, 0);
      tick();
      tick();
      reset = 1'b1;

      do_cmd(3, 0, 'hA5, -1, 1'b0);
      chk("load.q", 32'(q), 32'hA5);
      tick();
      chk_all("idle", 0, 0);

      do_cmd(1, 3, 0, 1, 1'b0);
      chk("shl.q", 32'(q), 32'h2F);
      chk("shl.sout", 32'(sout), 32'h1);

      do_cmd(3, 0, 'h96, -1, 1'b0);
      do_cmd(5, 12, 0, -1, 1'b0);
      chk("ror_sat.q", 32'(q), 32'h96);

      do_cmd(3, 0, 'h80, -1, 1'b0);
      do_cmd(6, 3, 0, -1, 1'b0);
      chk("asr.q", 32'(q), 32'hF0);
      chk("asr.sout", 32'(sout), 32'h0);

      do_cmd(3, 0, 'hA5, -1, 1'b0);
      do_cmd(1, 4, 0, -1, 1'b1);

      // Reset between E1 and E2 of a five-step shift.
      start = 1'b1;
      mode  = 3'b001;
      count = CW'(5);
      tick();
      start = 1'b0;
      sin   = 1'b1;
      tick();
      begin
         int so;
         mq    = step_fn(1, mq, 1, so);
         msout = so;
      end
      chk_all("pre_abort", 1, 0);
      #3 reset = 1'b0;
      #1;
      mq    = 0;
      msout = 0;
      chk_all("abort", 0, 0);
      tick();
      chk_all("abort_hold", 0, 0);
      reset = 1'b1;
      tick();
      chk_all("abort_after", 0, 0);

      do_cmd(3, 0, 'h3C, -1, 1'b0);
      do_cmd(4, 0, 0, -1, 1'b0);
      chk("rol0.q", 32'(q), 32'h3C);

      for (int i = 0; i < 60; i++) begin
         do_cmd(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(255, 0)), -1, 1'($urandom_range(1, 0)));
         if ($urandom_range(3, 0) == 0) begin
            tick();
            chk_all("gap", 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
